// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the PS/2 scan-code byte stream into clean make/break
// events and keeps a last-note-priority stack of held keys.
module ps2_key_tracker #(
    parameter int unsigned HOLD_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] note_key,
    output logic       note_ext,
    output logic       note_active,
    output logic [3:0] held_count,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    skip_cnt_q;

    logic          is_e0, is_f0, is_e1, is_ignored;
    logic          ev_make, ev_break;
    logic [8:0]    ev_key;

    // Stack entries are {ext, code}; entry 0 is the oldest, unused entries stay zero.
    logic [8:0]    stack_q [HOLD_DEPTH];
    logic [8:0]    stack_d [HOLD_DEPTH];
    logic [3:0]    count_q, count_d;
    logic          hit, ovf_d, new_make;
    logic [3:0]    hit_idx;
    logic [8:0]    top_d;

    assign is_e0      = (ps2_key_data == 8'hE0);
    assign is_f0      = (ps2_key_data == 8'hF0);
    assign is_e1      = (ps2_key_data == 8'hE1);
    assign is_ignored = ps2_key_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE};

    // Decode the incoming byte against the pending prefix into at most one event.
    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_key   = {1'b0, ps2_key_data};
        if (ps2_key_pressed) begin
            case (state_q)
                StIdle:   ev_make = !(is_e0 || is_f0 || is_e1 || is_ignored);
                StExt: begin
                    ev_make   = !(is_e0 || is_f0);
                    ev_key[8] = 1'b1;
                end
                StBrk:    ev_break = !(is_e0 || is_f0);
                StExtBrk: begin
                    ev_break  = !(is_e0 || is_f0);
                    ev_key[8] = 1'b1;
                end
                default:  ;
            endcase
        end
    end

    // Prefix FSM with inactivity timeout and pause-sequence skip counter.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            skip_cnt_q <= '0;
        end else if (ps2_key_pressed) begin
            timer_q <= '0;
            case (state_q)
                StIdle: begin
                    if (is_e0) begin
                        state_q <= StExt;
                    end else if (is_f0) begin
                        state_q <= StBrk;
                    end else if (is_e1) begin
                        state_q    <= StSkip;
                        skip_cnt_q <= 3'd7;
                    end
                end
                StExt: begin
                    if (is_f0) begin
                        state_q <= StExtBrk;
                    end else if (!is_e0) begin
                        state_q <= StIdle;
                    end
                end
                StSkip: begin
                    skip_cnt_q <= skip_cnt_q - 3'd1;
                    if (skip_cnt_q == 3'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_q    <= StIdle;
                timer_q    <= '0;
                skip_cnt_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Next stack contents: filter repeats, push with eviction, remove with compaction.
    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        hit     = 1'b0;
        hit_idx = '0;
        top_d   = '0;
        for (int i = 0; i < int'(HOLD_DEPTH); i++) begin
            if (i < int'(count_q) && stack_q[i] == ev_key) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
        if (ev_make && !hit) begin
            if (count_q == 4'(HOLD_DEPTH)) begin
                for (int i = 0; i < int'(HOLD_DEPTH) - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[HOLD_DEPTH-1] = ev_key;
                ovf_d                 = 1'b1;
            end else begin
                for (int i = 0; i < int'(HOLD_DEPTH); i++) begin
                    if (i == int'(count_q)) begin
                        stack_d[i] = ev_key;
                    end
                end
                count_d = count_q + 4'd1;
            end
        end else if (ev_break && hit) begin
            for (int i = 0; i < int'(HOLD_DEPTH) - 1; i++) begin
                if (i >= int'(hit_idx)) begin
                    stack_d[i] = stack_q[i+1];
                end
            end
            stack_d[HOLD_DEPTH-1] = '0;
            count_d               = count_q - 4'd1;
        end
        for (int i = 0; i < int'(HOLD_DEPTH); i++) begin
            if (i == int'(count_d) - 1) begin
                top_d = stack_d[i];
            end
        end
    end

    assign new_make = ev_make && !hit;

    // Register the stack and every output so events appear one cycle after the strobe.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            stack_q     <= '{default: '0};
            count_q     <= '0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            note_key    <= '0;
            note_ext    <= 1'b0;
            note_active <= 1'b0;
            held_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            stack_q     <= stack_d;
            count_q     <= count_d;
            make_pulse  <= new_make;
            break_pulse <= ev_break;
            overflow    <= ovf_d;
            if (new_make || ev_break) begin
                key_code <= ev_key[7:0];
                key_ext  <= ev_key[8];
            end
            note_key    <= top_d[7:0];
            note_ext    <= top_d[8];
            note_active <= (count_d != 4'd0);
            held_count  <= count_d;
        end
    end

endmodule
